// File: rtl/vec_normalize_scale.sv
// Pairs buffered Q8.24 direction vectors with their returned 1/|v| scalars in FIFO order
// and scales x, y, z through one shared saturating multiplier, one component per cycle.
module vec_normalize_scale #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] vec_x,
    input  logic [WIDTH-1:0] vec_y,
    input  logic [WIDTH-1:0] vec_z,
    input  logic             inv_valid,
    input  logic [WIDTH-1:0] inv_sqrt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic             ovf
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int FRAC = WIDTH - 8;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic signed [2*WIDTH-1:0] SAT_HI = $signed({{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [2*WIDTH-1:0] SAT_LO = $signed({{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

    typedef enum logic [2:0] {IDLE, MUL_X, MUL_Y, MUL_Z, DONE} state_t;

    // Full-precision product, arithmetic shift back to Q8.24, then clamp to the word range.
    function automatic logic signed [WIDTH-1:0] mul_sat(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] w_full;
        w_full = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        w_full = w_full >>> FRAC;
        if (w_full > SAT_HI)
            return $signed({1'b0, {(WIDTH-1){1'b1}}});
        else if (w_full < SAT_LO)
            return $signed({1'b1, {(WIDTH-1){1'b0}}});
        else
            return $signed(w_full[WIDTH-1:0]);
    endfunction

    logic signed [WIDTH-1:0] r_fx [DEPTH];
    logic signed [WIDTH-1:0] r_fy [DEPTH];
    logic signed [WIDTH-1:0] r_fz [DEPTH];
    logic signed [WIDTH-1:0] r_fs [DEPTH];
    logic [PW-1:0]           r_vwp, r_vrp, r_swp, r_srp;
    logic [CW-1:0]           r_vcnt, r_scnt;
    logic                    r_up;
    state_t                  r_state;
    logic signed [WIDTH-1:0] r_wx, r_wy, r_wz, r_ws;

    logic                    w_vpush, w_spush, w_both, w_pop;
    logic signed [WIDTH-1:0] w_op, w_prod;

    // r_up keeps vec_ready low through reset without looking at rst combinationally.
    assign vec_ready = r_up && (r_vcnt < FULL);
    assign w_vpush   = vec_valid && vec_ready;
    assign w_spush   = inv_valid && (r_scnt < FULL);
    assign w_both    = (r_vcnt != '0) && (r_scnt != '0);
    assign w_pop     = w_both && ((r_state == IDLE) || ((r_state == DONE) && out_ready));

    always_comb begin
        w_op = r_wx;
        case (r_state)
            MUL_Y:   w_op = r_wy;
            MUL_Z:   w_op = r_wz;
            default: w_op = r_wx;
        endcase
    end

    assign w_prod = mul_sat(w_op, r_ws);

    // Storage and working operands carry no reset; validity is tracked by counts and state.
    always_ff @(posedge clk) begin
        if (w_vpush) begin
            r_fx[r_vwp] <= vec_x;
            r_fy[r_vwp] <= vec_y;
            r_fz[r_vwp] <= vec_z;
        end
        if (w_spush)
            r_fs[r_swp] <= inv_sqrt;
        if (w_pop) begin
            r_wx <= r_fx[r_vrp];
            r_wy <= r_fy[r_vrp];
            r_wz <= r_fz[r_vrp];
            r_ws <= r_fs[r_srp];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up      <= 1'b0;
            r_vwp     <= '0;
            r_vrp     <= '0;
            r_swp     <= '0;
            r_srp     <= '0;
            r_vcnt    <= '0;
            r_scnt    <= '0;
            ovf       <= 1'b0;
            r_state   <= IDLE;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
        end else begin
            r_up <= 1'b1;
            if (w_vpush)
                r_vwp <= r_vwp + PW'(1);
            if (w_spush)
                r_swp <= r_swp + PW'(1);
            else if (inv_valid)
                ovf <= 1'b1;
            if (w_pop) begin
                r_vrp <= r_vrp + PW'(1);
                r_srp <= r_srp + PW'(1);
            end
            r_vcnt <= r_vcnt + CW'(w_vpush) - CW'(w_pop);
            r_scnt <= r_scnt + CW'(w_spush) - CW'(w_pop);

            case (r_state)
                IDLE: begin
                    if (w_pop)
                        r_state <= MUL_X;
                end
                MUL_X: begin
                    out_x   <= w_prod;
                    r_state <= MUL_Y;
                end
                MUL_Y: begin
                    out_y   <= w_prod;
                    r_state <= MUL_Z;
                end
                MUL_Z: begin
                    out_z     <= w_prod;
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= w_pop ? MUL_X : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_normalize_scale.sv
// Randomized bench for vec_normalize_scale against a queue-based pairing model.
module tb_vec_normalize_scale;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vec_valid = 1'b0;
    logic        vec_ready;
    logic [31:0] vec_x = '0, vec_y = '0, vec_z = '0;
    logic        inv_valid = 1'b0;
    logic [31:0] inv_sqrt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_x, out_y, out_z;
    logic        ovf;

    always #5 clk = ~clk;

    vec_normalize_scale #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_x(vec_x), .vec_y(vec_y), .vec_z(vec_z),
        .inv_valid(inv_valid), .inv_sqrt(inv_sqrt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .ovf(ovf)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [95:0] obs_q[$];
    int          obs_cyc[$];
    logic [95:0] exp_q[$];
    logic [31:0] mvx[$], mvy[$], mvz[$], ms_q[$];
    bit          m_ovf;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back({out_x, out_y, out_z});
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 24;
        if (p > 64'sd2147483647) return 32'h7FFFFFFF;
        if (p < -64'sd2147483648) return 32'h80000000;
        return p[31:0];
    endfunction

    task automatic model_pair();
        logic [31:0] x, y, z, s;
        while (mvx.size() > 0 && ms_q.size() > 0) begin
            x = mvx.pop_front(); y = mvy.pop_front(); z = mvz.pop_front();
            s = ms_q.pop_front();
            exp_q.push_back({ref_mul(x, s), ref_mul(y, s), ref_mul(z, s)});
        end
    endtask

    task automatic model_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        mvx.push_back(x); mvy.push_back(y); mvz.push_back(z);
        model_pair();
    endtask

    task automatic model_scal(input logic [31:0] s);
        if (ms_q.size() < 4) ms_q.push_back(s);
        else m_ovf = 1'b1;
        model_pair();
    endtask

    task automatic clear_all();
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        mvx.delete(); mvy.delete(); mvz.delete(); ms_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        int n = 0;
        while (!vec_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!vec_ready) begin
            checks++; errors++;
            $display("FAIL push_vec_timeout: vec_ready=%b after %0d cycles, need 1", vec_ready, n);
        end
        vec_valid = 1'b1; vec_x = x; vec_y = y; vec_z = z;
        model_vec(x, y, z);
        @(posedge clk); #1;
        vec_valid = 1'b0;
    endtask

    task automatic push_scal(input logic [31:0] s);
        inv_valid = 1'b1; inv_sqrt = s;
        model_scal(s);
        @(posedge clk); #1;
        inv_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int k = 0;
        while (!out_valid && k < budget) begin @(posedge clk); #1; k++; end
        ok = out_valid;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin @(posedge clk); #1; k++; end
        ok = (obs_q.size() >= n);
    endtask

    task automatic do_reset();
        vec_valid = 1'b0; inv_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(1);
        clear_all();
    endtask

    task automatic test_reset();
        vec_valid = 1'b0; inv_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        cycles(3);
        checks++; if (vec_ready !== 1'b0) begin errors++; $display("FAIL reset_vec_ready: got %b want 0", vec_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++;
        if ({out_x, out_y, out_z} !== 96'h0) begin
            errors++; $display("FAIL reset_out_data: got %h want 0", {out_x, out_y, out_z});
        end
        rst = 1'b0;
        cycles(1);
        checks++; if (vec_ready !== 1'b1) begin errors++; $display("FAIL post_reset_vec_ready: got %b want 1", vec_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
        clear_all();
    endtask

    task automatic test_basic();
        bit exp_v;
        out_ready = 1'b0;
        push_vec(32'h03000000, 32'h04000000, 32'h00000000);
        push_scal(32'h00333333);
        for (int k = 1; k <= 4; k++) begin
            cycles(1);
            exp_v = (k == 4);
            checks++;
            if (out_valid !== exp_v) begin
                errors++; $display("FAIL basic_latency_e%0d: out_valid=%b want %b", k, out_valid, exp_v);
            end
        end
        checks++;
        if ({out_x, out_y, out_z} !== {32'h00999999, 32'h00CCCCCC, 32'h00000000}) begin
            errors++; $display("FAIL basic_data: got %h want %h", {out_x, out_y, out_z},
                               {32'h00999999, 32'h00CCCCCC, 32'h00000000});
        end
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: out_valid=%b want 0", out_valid); end
        clear_all();
    endtask

    task automatic test_sign_sat();
        bit ok;
        out_ready = 1'b0;
        push_vec(32'hFE000000, 32'h0, 32'h0);
        push_scal(32'h00800000);
        push_vec(32'h7F000000, 32'h81000000, 32'h0);
        push_scal(32'h02000000);
        wait_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sign_valid_timeout: out_valid=%b want 1", out_valid); end
        checks++;
        if ({out_x, out_y, out_z} !== {32'hFF000000, 32'h0, 32'h0}) begin
            errors++; $display("FAIL sign_data: got %h want %h", {out_x, out_y, out_z}, {32'hFF000000, 64'h0});
        end
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        wait_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_valid_timeout: out_valid=%b want 1", out_valid); end
        checks++;
        if ({out_x, out_y, out_z} !== {32'h7FFFFFFF, 32'h80000000, 32'h0}) begin
            errors++; $display("FAIL sat_data: got %h want %h", {out_x, out_y, out_z},
                               {32'h7FFFFFFF, 32'h80000000, 32'h0});
        end
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        clear_all();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [95:0] held;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_vec($urandom, $urandom, $urandom);
        checks++; if (vec_ready !== 1'b0) begin errors++; $display("FAIL bp_full: vec_ready=%b want 0", vec_ready); end
        push_scal($urandom);
        checks++; if (vec_ready !== 1'b0) begin errors++; $display("FAIL bp_before_pop: vec_ready=%b want 0", vec_ready); end
        push_scal($urandom);
        checks++; if (vec_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop: vec_ready=%b want 1", vec_ready); end
        push_scal($urandom);
        push_scal($urandom);
        wait_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_valid_timeout: out_valid=%b want 1", out_valid); end
        held = {out_x, out_y, out_z};
        checks++;
        if (held !== exp_q[0]) begin errors++; $display("FAIL bp_first_data: got %h want %h", held, exp_q[0]); end
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            checks++;
            if (out_valid !== 1'b1 || {out_x, out_y, out_z} !== held) begin
                errors++; $display("FAIL bp_stable_%0d: valid=%b data=%h want 1 %h", i, out_valid,
                                   {out_x, out_y, out_z}, held);
            end
        end
        out_ready = 1'b1;
        wait_obs(4, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain_timeout: got %0d outputs want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 1; i < 4 && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] - obs_cyc[i-1] != 4) begin
                errors++; $display("FAIL bp_spacing_%0d: got %0d cycles want 4", i, obs_cyc[i] - obs_cyc[i-1]);
            end
        end
        out_ready = 1'b0;
        clear_all();
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_scal($urandom);
            checks++;
            if (ovf !== m_ovf) begin errors++; $display("FAIL ovf_pulse_%0d: ovf=%b want %b", i, ovf, m_ovf); end
        end
        for (int i = 0; i < 4; i++) push_vec($urandom, $urandom, $urandom);
        wait_obs(4, 60, ok);
        cycles(12);
        checks++;
        if (obs_q.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d outputs want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_data_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: ovf=%b want 1", ovf); end
        out_ready = 1'b0;
        clear_all();
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_vec(32'h01000000, 32'h02000000, 32'h03000000);
        push_scal(32'h01000000);
        cycles(2);
        rst = 1'b1;
        cycles(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
        checks++; if (out_x !== 32'h0) begin errors++; $display("FAIL midrst_out_x: got %h want 0", out_x); end
        rst = 1'b0;
        clear_all();
        out_ready = 1'b1;
        cycles(10);
        checks++;
        if (obs_q.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet: got %0d outputs valid=%b want 0 0", obs_q.size(), out_valid);
        end
        push_vec($urandom, $urandom, $urandom);
        push_scal($urandom);
        wait_obs(1, 20, ok);
        cycles(10);
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d outputs want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL midrst_data: got %h want %h", obs_q[0], exp_q[0]); end
        end
        out_ready = 1'b0;
        clear_all();
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [31:0] x, y, z, s;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_vec($urandom, $urandom, $urandom);
        s = $urandom;
        inv_valid = 1'b1; inv_sqrt = s;
        model_scal(s);
        @(posedge clk); #1;
        inv_valid = 1'b0;
        x = $urandom; y = $urandom; z = $urandom;
        vec_valid = 1'b1; vec_x = x; vec_y = y; vec_z = z;
        model_vec(x, y, z);
        @(posedge clk); #1;
        vec_valid = 1'b0;
        checks++; if (vec_ready !== 1'b1) begin errors++; $display("FAIL simul_count_kept: vec_ready=%b want 1", vec_ready); end
        push_vec($urandom, $urandom, $urandom);
        checks++; if (vec_ready !== 1'b0) begin errors++; $display("FAIL simul_now_full: vec_ready=%b want 0", vec_ready); end
        for (int i = 0; i < 4; i++) push_scal($urandom);
        wait_obs(5, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_timeout: got %0d outputs want 5", obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL simul_data_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b want 0", ovf); end
        out_ready = 1'b0;
        clear_all();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_sat();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
